// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: requester A/B handshakes, issue/operand
// scoreboard queries and the registered register-file write port.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [AW:0]     pend_cnt;
  logic            rf_w_en;
  logic [AW-1:0]   rf_w_addr;
  logic [XLEN-1:0] rf_w_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output iss_en, iss_addr,
    output rs1_addr, rs2_addr,
    input  a_ready, b_ready,
    input  rs1_busy, rs2_busy, pend_cnt,
    input  rf_w_en, rf_w_addr, rf_w_data
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  iss_en, iss_addr,
    input  rs1_addr, rs2_addr,
    output a_ready, b_ready,
    output rs1_busy, rs2_busy, pend_cnt,
    output rf_w_en, rf_w_addr, rf_w_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a pending-write
// scoreboard. Ports: clk, rst_n (async low), bus (slave side of rf_wb_arbiter_if).
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int NR = 1 << AW;

  typedef enum logic {
    PRIO_A,
    PRIO_B
  } prio_e;

  prio_e           prio_q, prio_d;
  logic [NR-1:0]   sb_q, sb_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            w_en_q;
  logic [AW-1:0]   w_addr_q;
  logic [XLEN-1:0] w_data_q;

  logic            a_rdy, b_rdy, grant;
  logic [AW-1:0]   g_addr;
  logic [XLEN-1:0] g_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= PRIO_A;
      sb_q     <= '0;
      cnt_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      prio_q <= prio_d;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      w_en_q <= grant && (g_addr != '0);
      if (grant) begin
        w_addr_q <= g_addr;
        w_data_q <= g_data;
      end
    end
  end

  always_comb begin
    a_rdy  = bus.a_valid & (~bus.b_valid | (prio_q == PRIO_A));
    b_rdy  = bus.b_valid & (~bus.a_valid | (prio_q == PRIO_B));
    grant  = a_rdy | b_rdy;
    prio_d = prio_q;
    g_addr = bus.a_addr;
    g_data = bus.a_data;
    unique case (1'b1)
      a_rdy: prio_d = PRIO_B;
      b_rdy: begin
        prio_d = PRIO_A;
        g_addr = bus.b_addr;
        g_data = bus.b_data;
      end
      default: prio_d = prio_q;
    endcase
  end

  // Set is applied after clear so a newer producer keeps the bit.
  always_comb begin
    sb_d = sb_q;
    if (w_en_q)
      sb_d[w_addr_q] = 1'b0;
    if (bus.iss_en && (bus.iss_addr != '0))
      sb_d[bus.iss_addr] = 1'b1;
    sb_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NR; i++)
      cnt_d = cnt_d + (AW+1)'(sb_d[i]);
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.rs1_busy  = sb_q[bus.rs1_addr];
  assign bus.rs2_busy  = sb_q[bus.rs2_addr];
  assign bus.pend_cnt  = cnt_q;
  assign bus.rf_w_en   = w_en_q;
  assign bus.rf_w_addr = w_addr_q;
  assign bus.rf_w_data = w_data_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus random bench for rf_wb_arbiter against a cycle-level
// reference model of grants, write stage and pending-write set.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncomp = 0;
  int nfail = 0;

  rf_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

  rf_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // reference model
  bit          mpend[32];
  int          mlast;
  bit          mwen;
  logic [4:0]  mwaddr;
  logic [31:0] mwdata;
  int          mgrant;

  task automatic mreset();
    foreach (mpend[i]) mpend[i] = 1'b0;
    mlast  = 1;
    mwen   = 1'b0;
    mwaddr = '0;
    mwdata = '0;
    mgrant = 0;
  endtask

  function automatic int mcount();
    int n = 0;
    foreach (mpend[i]) n += int'(mpend[i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; combinational outputs are
  // checked mid-cycle, registered outputs just after the next edge.
  task automatic cycle();
    bit ea, eb, b1, b2;
    #4;
    ea = bus.a_valid && (!bus.b_valid || mlast == 1);
    eb = bus.b_valid && (!bus.a_valid || mlast == 0);
    b1 = mpend[bus.rs1_addr];
    b2 = mpend[bus.rs2_addr];
    chk("a_ready", 64'(bus.a_ready), 64'(ea));
    chk("b_ready", 64'(bus.b_ready), 64'(eb));
    chk("rs1_busy", 64'(bus.rs1_busy), 64'(b1));
    chk("rs2_busy", 64'(bus.rs2_busy), 64'(b2));
    if (mwen) mpend[mwaddr] = 1'b0;
    if (bus.iss_en && bus.iss_addr != 0) mpend[bus.iss_addr] = 1'b1;
    mgrant = 0;
    if (ea) begin
      mwen = (bus.a_addr != 0); mwaddr = bus.a_addr;
      mwdata = bus.a_data; mlast = 0; mgrant = 1;
    end else if (eb) begin
      mwen = (bus.b_addr != 0); mwaddr = bus.b_addr;
      mwdata = bus.b_data; mlast = 1; mgrant = 2;
    end else begin
      mwen = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_w_en", 64'(bus.rf_w_en), 64'(mwen));
    chk("rf_w_addr", 64'(bus.rf_w_addr), 64'(mwaddr));
    chk("rf_w_data", 64'(bus.rf_w_data), 64'(mwdata));
    chk("pend_cnt", 64'(bus.pend_cnt), 64'(mcount()));
  endtask

  task automatic idle_in();
    bus.a_valid = 0; bus.b_valid = 0; bus.iss_en = 0;
  endtask

  initial begin
    logic [4:0] order[4];
    int ai, bi;
    mreset();
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.iss_en = 0; bus.iss_addr = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;

    // reset then idle
    #12;
    chk("rst_w_en", 64'(bus.rf_w_en), 64'd0);
    chk("rst_cnt", 64'(bus.pend_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      #0.1;
      chk("idle_rs1_busy", 64'(bus.rs1_busy), 64'd0);
    end
    bus.rs1_addr = 0;
    cycle();
    chk("idle_w_addr", 64'(bus.rf_w_addr), 64'd0);
    chk("idle_w_data", 64'(bus.rf_w_data), 64'd0);

    // single A write
    bus.a_valid = 1; bus.a_addr = 5; bus.a_data = 32'hDEADBEEF;
    cycle();
    chk("single_en", 64'(bus.rf_w_en), 64'd1);
    chk("single_addr", 64'(bus.rf_w_addr), 64'd5);
    chk("single_data", 64'(bus.rf_w_data), 64'hDEADBEEF);
    idle_in();
    cycle();
    chk("single_en_drop", 64'(bus.rf_w_en), 64'd0);

    // x0 write by B: accepted, no write, favour returns to A
    bus.b_valid = 1; bus.b_addr = 0; bus.b_data = 32'h1234;
    cycle();
    chk("x0_en", 64'(bus.rf_w_en), 64'd0);
    chk("x0_cnt", 64'(bus.pend_cnt), 64'd0);

    // contention, prio = A
    order[0] = 5'd1; order[1] = 5'd11; order[2] = 5'd2; order[3] = 5'd12;
    ai = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      bus.a_valid = 1; bus.a_addr = 5'(1 + ai); bus.a_data = 32'(100 + ai);
      bus.b_valid = 1; bus.b_addr = 5'(11 + bi); bus.b_data = 32'(200 + bi);
      cycle();
      chk("cont_order", 64'(bus.rf_w_addr), 64'(order[k]));
      chk("cont_en", 64'(bus.rf_w_en), 64'd1);
      if (mgrant == 1) ai++;
      if (mgrant == 2) bi++;
    end
    idle_in();
    cycle();

    // scoreboard lifecycle on x7
    bus.iss_en = 1; bus.iss_addr = 7;
    cycle();
    bus.iss_en = 0; bus.rs1_addr = 7;
    #1;
    chk("sb7_busy", 64'(bus.rs1_busy), 64'd1);
    chk("sb7_cnt", 64'(bus.pend_cnt), 64'd1);
    bus.a_valid = 1; bus.a_addr = 7; bus.a_data = 32'h77;
    cycle();
    idle_in();
    cycle();
    #1;
    chk("sb7_clear_busy", 64'(bus.rs1_busy), 64'd0);
    chk("sb7_clear_cnt", 64'(bus.pend_cnt), 64'd0);

    // set/clear collision on x9
    bus.iss_en = 1; bus.iss_addr = 9;
    cycle();
    bus.iss_en = 0;
    bus.b_valid = 1; bus.b_addr = 9; bus.b_data = 32'h99;
    cycle();
    bus.b_valid = 0;
    bus.iss_en = 1; bus.iss_addr = 9;
    cycle();
    idle_in();
    bus.rs1_addr = 9;
    #1;
    chk("coll_busy", 64'(bus.rs1_busy), 64'd1);
    chk("coll_cnt", 64'(bus.pend_cnt), 64'd1);

    // reset while a write is in flight
    bus.a_valid = 1; bus.a_addr = 3; bus.a_data = 32'h33;
    cycle();
    idle_in();
    chk("mid_en_before", 64'(bus.rf_w_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_en_after", 64'(bus.rf_w_en), 64'd0);
    chk("mid_cnt", 64'(bus.pend_cnt), 64'd0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (!bus.a_valid || mgrant == 1) begin
        bus.a_valid = ($urandom % 4) != 0;
        bus.a_addr = 5'($urandom); bus.a_data = $urandom;
      end
      if (!bus.b_valid || mgrant == 2) begin
        bus.b_valid = ($urandom % 3) != 0;
        bus.b_addr = 5'($urandom); bus.b_data = $urandom;
      end
      bus.iss_en = $urandom % 2;
      bus.iss_addr = 5'($urandom);
      bus.rs1_addr = 5'($urandom);
      bus.rs2_addr = 5'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
